// File: rtl/mod_count_checker_if.sv
// mod_count_if -- connection between a mod-N counter and its sequence checker.
//
// Signals:
//   count    counter value; the counter (master) drives it every cycle
//   locked   checker has seen LOCK_WRAPS consecutive clean wraps
//   err      one-cycle pulse for each detected sequence error
//   err_cnt  saturating count of errors (stops at 255)
//   oor      sticky flag; a value >= MOD was seen
//   wraps    saturating count of clean wraps since the last (re)sync
//
// Modports:
//   master   counter side: drives count and may observe the checker status
//   slave    checker side: observes count and drives the status signals
interface mod_count_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] count;
  logic             locked;
  logic             err;
  logic [7:0]       err_cnt;
  logic             oor;
  logic [7:0]       wraps;

  modport master (output count, input locked, err, err_cnt, oor, wraps);
  modport slave  (input count, output locked, err, err_cnt, oor, wraps);
endinterface

// File: rtl/mod_count_checker.sv
// mod_count_checker -- observes a mod-MOD counter and confirms that it steps
// 0, 1, ..., MOD-1, 0 once per clock. It never drives the counter.
//
// The count bus is WIDTH bits wide and the modulus may be anything from 2 up
// to 2**WIDTH. The locked flag rises after LOCK_WRAPS consecutive clean wraps.
// Sampling happens on every rising clock edge. The active-low reset is
// asynchronous and clears every status output at once. The checker connects
// through the slave side of mod_count_if.
//
// SEARCH waits for a 0 before tracking begins. TRACK compares every sample
// with the expected value. A mismatch that is itself a 0 resyncs immediately.
// Any other mismatch drops back to SEARCH. Every output is a register that
// reflects the sample taken on the edge that produced it.
module mod_count_checker #(
  parameter int WIDTH      = 3,
  parameter int MOD        = 6,
  parameter int LOCK_WRAPS = 2
) (
  input  logic          clk,
  input  logic          rst,
  mod_count_if.slave    cif
);

  // The terminal value is compared as a WIDTH-bit constant, so MOD = 2**WIDTH
  // wraps at all-ones. The range check is one bit wider, so oor can never set
  // in that case.
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MOD);
  localparam logic [7:0]       LOCK_W = 8'(LOCK_WRAPS);

  typedef enum logic {SEARCH, TRACK} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_p1;
  logic [WIDTH-1:0] exp_p1;
  logic             locked_p1;
  logic             err_p1;
  logic [7:0]       err_cnt_p1;
  logic             oor_p1;
  logic [7:0]       wraps_p1;

  logic             is_oor;
  logic [7:0]       wraps_inc;

  assign is_oor    = ({1'b0, cif.count} >= MOD_W);
  assign wraps_inc = sat_inc8(wraps_p1);

  // ---- stage p1: sample count, update FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1   <= SEARCH;
      exp_p1     <= '0;
      locked_p1  <= 1'b0;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
      oor_p1     <= 1'b0;
      wraps_p1   <= '0;
    end else begin
      err_p1 <= 1'b0;
      if (is_oor) begin
        oor_p1 <= 1'b1;
      end
      case (state_p1)
        SEARCH: begin
          // Nonzero samples are ignored here. They are not errors.
          if (cif.count == '0) begin
            state_p1 <= TRACK;
            exp_p1   <= WIDTH'(1);
          end
        end
        TRACK: begin
          if (cif.count == exp_p1) begin
            exp_p1 <= (exp_p1 == LAST) ? '0 : exp_p1 + WIDTH'(1);
            if (cif.count == LAST) begin
              wraps_p1 <= wraps_inc;
              // Once set, locked stays set until the next error.
              if (wraps_inc == LOCK_W) begin
                locked_p1 <= 1'b1;
              end
            end
          end else begin
            err_p1     <= 1'b1;
            err_cnt_p1 <= sat_inc8(err_cnt_p1);
            locked_p1  <= 1'b0;
            wraps_p1   <= '0;
            // A premature 0 is still an error, but it is a valid restart point.
            if (cif.count == '0) begin
              exp_p1 <= WIDTH'(1);
            end else begin
              state_p1 <= SEARCH;
            end
          end
        end
        default: begin
          state_p1 <= SEARCH;
        end
      endcase
    end
  end

  assign cif.locked  = locked_p1;
  assign cif.err     = err_p1;
  assign cif.err_cnt = err_cnt_p1;
  assign cif.oor     = oor_p1;
  assign cif.wraps   = wraps_p1;

endmodule

// File: tb/tb_mod_count_checker.sv
module tb_mod_count_checker;
  localparam int WIDTH      = 3;
  localparam int MOD        = 6;
  localparam int LOCK_WRAPS = 2;

  logic clk;
  logic rst;

  mod_count_if #(.WIDTH(WIDTH)) cif ();

  mod_count_checker #(
    .WIDTH     (WIDTH),
    .MOD       (MOD),
    .LOCK_WRAPS(LOCK_WRAPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cif(cif)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct {
    bit locked;
    bit err;
    int err_cnt;
    bit oor;
    int wraps;
  } exp_t;

  exp_t sbq[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: tracking flag, next expected value, and output values.
  bit m_track;
  int m_exp;
  bit m_locked, m_err, m_oor;
  int m_errs, m_wraps;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_track = 0; m_exp = 0;
    m_locked = 0; m_err = 0; m_oor = 0;
    m_errs = 0; m_wraps = 0;
  endtask

  task automatic model_step(input int v);
    m_err = 0;
    if (v >= MOD) m_oor = 1;
    if (!m_track) begin
      if (v == 0) begin
        m_track = 1;
        m_exp = 1;
      end
    end else if (v == m_exp) begin
      m_exp = (v + 1) % MOD;
      if (v == MOD - 1) begin
        if (m_wraps < 255) m_wraps++;
        if (m_wraps == LOCK_WRAPS) m_locked = 1;
      end
    end else begin
      m_err = 1;
      if (m_errs < 255) m_errs++;
      m_locked = 0;
      m_wraps = 0;
      if (v == 0) m_exp = 1;
      else m_track = 0;
    end
  endtask

  // Called at a falling edge: present v, record the expected response of the
  // coming rising edge, then move on to the next falling edge.
  task automatic step(input int v);
    exp_t e;
    cif.count = WIDTH'(v);
    model_step(v);
    e.locked = m_locked; e.err = m_err; e.err_cnt = m_errs;
    e.oor = m_oor; e.wraps = m_wraps;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic clean_wraps(input int n);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < MOD; k++) step(k);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, "_locked"},  cif.locked,  0);
    chk({tag, "_err"},     cif.err,     0);
    chk({tag, "_err_cnt"}, cif.err_cnt, 0);
    chk({tag, "_oor"},     cif.oor,     0);
    chk({tag, "_wraps"},   cif.wraps,   0);
  endtask

  // Monitor: every rising edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_locked",  cif.locked,  e.locked);
        chk("sb_err",     cif.err,     e.err);
        chk("sb_err_cnt", cif.err_cnt, e.err_cnt);
        chk("sb_oor",     cif.oor,     e.oor);
        chk("sb_wraps",   cif.wraps,   e.wraps);
      end
    end
  end

  initial begin
    int nxt;
    int v;
    rst = 1'b1;
    cif.count = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 expect_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Clean run: lock at the 12th sampling edge.
    clean_wraps(2);
    chk("clean_locked", cif.locked, 1);
    chk("clean_wraps2", cif.wraps, 2);
    clean_wraps(1);
    chk("clean_wraps3", cif.wraps, 3);
    clean_wraps(1);

    // Skip: 0,1,2,4,5,0,1, then finish the wrap.
    step(0); step(1); step(2); step(4);
    chk("skip_err", cif.err, 1);
    chk("skip_err_cnt", cif.err_cnt, 1);
    chk("skip_locked", cif.locked, 0);
    step(5);
    chk("skip_ignored", cif.err, 0);
    step(0); step(1);
    chk("skip_resync", cif.err, 0);
    step(2); step(3); step(4); step(5);

    // Early restart.
    step(0); step(1); step(2); step(0);
    chk("early_err", cif.err, 1);
    step(1); step(2); step(3); step(4); step(5);
    chk("early_err_cnt", cif.err_cnt, 2);

    // Out-of-range in TRACK, then relock.
    step(0); step(1); step(7);
    chk("oor_set", cif.oor, 1);
    chk("oor_err", cif.err, 1);
    clean_wraps(2);
    chk("oor_sticky", cif.oor, 1);
    chk("oor_relock", cif.locked, 1);
    chk("oor_err_cnt", cif.err_cnt, 3);

    // Reset between edges while locked with err_cnt = 3.
    #1 rst = 1'b0;
    #1 expect_zero("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clean_wraps(2);
    chk("post_reset_locked", cif.locked, 1);
    chk("post_reset_oor", cif.oor, 0);

    // Randomized stream: mostly a correct sequence with occasional corruption.
    nxt = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, (1 << WIDTH) - 1));
      else v = nxt;
      nxt = (v < MOD) ? (v + 1) % MOD : 0;
      step(v);
    end

    // Saturation: alternating 0,3.
    for (int i = 0; i < 600; i++) step((i % 2 == 0) ? 0 : 3);
    chk("sat_err_cnt", cif.err_cnt, 255);
    chk("sat_locked", cif.locked, 0);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
